// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader that writes an image into RAM,
// verifies its trailing checksum and releases the core only on a good frame.
module prog_loader #(
  parameter int AW = 20,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_we,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          run
);
  typedef enum logic [2:0] {IDLE, ADR0, ADR1, ADR2, LEN0, LEN1, DATA, CSUM} state_t;
  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic [LW-1:0] r_cnt;
  logic [7:0]    r_sum;
  logic          r_rdy;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_data;
  logic          r_mem_we;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_run;
  logic          w_acc;
  logic [7:0]    w_sum;
  logic [LW-1:0] w_len;
  assign w_acc    = in_valid && r_rdy;
  assign w_sum    = r_sum + in_data;
  assign w_len    = r_cnt | LW'({in_data, 8'h00});
  assign in_ready = r_rdy;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_we   = r_mem_we;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign run      = r_run;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_rdy      <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_rdy    <= 1'b1;
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      if (w_acc) begin
        if (r_state != IDLE) r_sum <= w_sum;
        case (r_state)
          IDLE: if (in_data == 8'hA5) begin
            r_state <= ADR0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_run   <= 1'b0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
          end
          ADR0: begin
            r_ptr   <= AW'(in_data);
            r_state <= ADR1;
          end
          ADR1: begin
            r_ptr   <= r_ptr | AW'({in_data, 8'h00});
            r_state <= ADR2;
          end
          ADR2: begin
            r_ptr   <= r_ptr | AW'({in_data, 16'h0000});
            r_state <= LEN0;
          end
          LEN0: begin
            r_cnt   <= LW'(in_data);
            r_state <= LEN1;
          end
          LEN1: begin
            r_cnt   <= w_len;
            r_state <= (w_len == '0) ? CSUM : DATA;
          end
          DATA: begin
            r_mem_addr <= r_ptr;
            r_mem_data <= in_data;
            r_mem_we   <= 1'b1;
            r_ptr      <= r_ptr + 1'b1;
            r_cnt      <= r_cnt - 1'b1;
            r_state    <= (r_cnt == LW'(1)) ? CSUM : DATA;
          end
          CSUM: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_run   <= (w_sum == 8'h00);
            r_err   <= (w_sum != 8'h00);
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule
